mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Memory-access stage feeding memwb_reg. Takes the registered EX/MEM instruction, runs one
//  data-bus transaction (req/addr_ok/data_ok) for loads and stores, and stalls the pipeline
//  until the transaction finishes. It presents mem_* signals that memwb_reg samples every cycle.
//  Load data leaves as the raw word plus a byte-enable (mem_dre); the WB stage does alignment.
// PARAMETERS
//  AW  32  data-bus address width
//  DW  32  data-bus data width (fixed to 4 byte lanes)
// PORTS
//  clk          in   1   clock, all state changes on rising edge
//  rst          in   1   synchronous reset, active-high
//  flush        in   1   exception/ERET squash of the instruction in this stage
//  in_valid     in   1   EX/MEM holds a valid instruction
//  in_memtype   in   8   one-hot {SW,SH,SB,LW,LHU,LH,LBU,LB} (bit7..bit0); 0 = not a memory op
//  in_daddr     in   AW  effective address
//  in_wdata     in   DW  store data (rt), low-aligned
//  in_alures    in   DW  ALU result for non-load writeback
//  in_wreg      in   1   GPR write enable
//  in_wa        in   5   GPR write address
//  stall_req    out  1   hold IF..EX/MEM; upstream keeps in_* stable while high
//  d_req        out  1   data-bus request
//  d_wr         out  1   1 = store
//  d_be         out  4   byte-lane enables
//  d_addr       out  AW  word address ({in_daddr[AW-1:2],2'b00})
//  d_wdata      out  DW  store data replicated into lanes
//  d_addr_ok    in   1   request accepted this cycle
//  d_data_ok    in   1   read data valid / write done this cycle
//  d_rdata      in   DW  read data
//  mem_memtype  out  8   to memwb_reg
//  mem_wreg     out  1   to memwb_reg
//  mem_wa       out  5   to memwb_reg
//  mem_dreg     out  DW  load: raw buffered word; otherwise in_alures
//  mem_dre      out  4   load byte enables (0 for non-loads)
//  mem_daddr    out  AW  in_daddr (WB uses [1:0] for alignment)
//  mem_adel     out  1   load address error (one cycle)
//  mem_ades     out  1   store address error (one cycle)
// BEHAVIOUR
//  Reset: state=IDLE, rdata_buf=0; while rst is high, every output is 0.
//  Lanes: byte ops use be=1<<addr[1:0]; half ops use be=addr[1]?1100:0011; word ops use 1111.
//   SB replicates {4{wdata[7:0]}}; SH replicates {2{wdata[15:0]}}; SW passes wdata through.
//  Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. No request is made; adel/ades=1 for one
//   cycle; mem_wreg=0; stall_req=0.
//  FSM with 4 states:
//   IDLE: non-mem op passes through with 0 latency and stall_req=0.
//    Aligned mem op with ~flush: d_req=1 and stall_req=1.
//    When addr_ok=1 the next state is WAIT; otherwise hold d_req and its fields.
//   WAIT: d_req=0, stall_req=1, bubble out. On data_ok, latch d_rdata into rdata_buf and go to DONE.
//   DONE: stall_req=0. Outputs carry the instruction, with load mem_dreg=rdata_buf. Next is IDLE.
//   CANCEL: d_req=0, stall_req=1, bubble out. On data_ok, discard the data and go to IDLE.
//  Bubble means mem_wreg=0, mem_memtype=0, mem_dre=0, adel=ades=0.
//   Outputs are a bubble in every stalled cycle so memwb_reg never double-writes.
//  data_ok is taken as earliest in the cycle after addr_ok; data_ok is ignored in IDLE and DONE.
//  Only one transaction is outstanding.
//  Flush handling:
//   - d_req is gated by ~flush, so nothing is issued during a flush cycle.
//   - Flush in WAIT, or in IDLE with addr_ok already seen, goes to CANCEL; the bus response
//     must still be drained.
//   - Flush in DONE squashes the outputs to a bubble; next state is IDLE.
//  Latency: load/store with addr_ok in C0 and data_ok in C1 gives DONE in C2. Stall is high in C0-C1.
// TESTING
//  ALU op: in_memtype=0, alures=0x1234, wa=5, wreg=1 -> same cycle: mem_dreg=0x1234, stall_req=0, d_req=0.
//  LB at 0x1002:
//   - addr_ok in C0, data_ok in C1 with rdata=0xAABBCCDD.
//   - Expect d_be=0100 and stall in C0-C1.
//   - C2: mem_dreg=0xAABBCCDD, mem_dre=0100, wreg=1.
//  SH at 0x2002, wdata=0x0000BEEF, addr_ok delayed 3 cycles:
//   - d_req, d_be=1100, d_wdata=0xBEEFBEEF held stable throughout.
//   - mem_wreg=0 in all cycles.
//  LW at 0x3001 -> mem_adel=1 for one cycle, no d_req, no stall.
//   SW at 0x3002 -> mem_ades=1 for one cycle, no d_req, no stall.
//  Flush one cycle after addr_ok (WAIT):
//   - CANCEL holds stall until data_ok; no wreg pulse.
//   - A following LW issues d_req only after data_ok.
//  rst asserted in WAIT -> next cycle IDLE with all outputs 0; a stray data_ok is ignored.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-bus handshake between the memory-access stage and data memory
interface mem_access_stage_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          d_req;
    logic          d_wr;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_addr_ok;
    logic          d_data_ok;
    logic [DW-1:0] d_rdata;

    modport master (
        output d_req, d_wr, d_be, d_addr, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata
    );

    modport slave (
        input  d_req, d_wr, d_be, d_addr, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage: one data-bus transaction per load/store, stalls until done
module mem_access_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [7:0]            in_memtype,
    input  logic [AW-1:0]         in_daddr,
    input  logic [DW-1:0]         in_wdata,
    input  logic [DW-1:0]         in_alures,
    input  logic                  in_wreg,
    input  logic [4:0]            in_wa,
    output logic                  stall_req,
    mem_access_stage_if.master    dbus,
    output logic [7:0]            mem_memtype,
    output logic                  mem_wreg,
    output logic [4:0]            mem_wa,
    output logic [DW-1:0]         mem_dreg,
    output logic [3:0]            mem_dre,
    output logic [AW-1:0]         mem_daddr,
    output logic                  mem_adel,
    output logic                  mem_ades
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, CANCEL} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] rdata_buf;

    logic          is_load, is_store, is_byte, is_half, is_word;
    logic          mem_op, misaligned;
    logic [3:0]    be;
    logic [DW-1:0] wdata_lanes;
    logic          req, stall, emit, addr_err;
    logic          req_on, emit_on;

    // memtype one-hot: {SW,SH,SB,LW,LHU,LH,LBU,LB}
    assign is_load    = |in_memtype[4:0];
    assign is_store   = |in_memtype[7:5];
    assign is_byte    = in_memtype[0] | in_memtype[1] | in_memtype[5];
    assign is_half    = in_memtype[2] | in_memtype[3] | in_memtype[6];
    assign is_word    = in_memtype[4] | in_memtype[7];
    assign mem_op     = in_valid & (is_load | is_store);
    assign misaligned = (is_half & in_daddr[0]) | (is_word & (in_daddr[1:0] != 2'b00));

    always_comb begin
        be          = 4'b1111;
        wdata_lanes = in_wdata;
        if (is_byte) begin
            be          = 4'b0001 << in_daddr[1:0];
            wdata_lanes = {4{in_wdata[7:0]}};
        end else if (is_half) begin
            be          = in_daddr[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{in_wdata[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdata_buf <= '0;
        end else begin
            state <= state_nx;
            if (state == WAIT && dbus.d_data_ok)
                rdata_buf <= dbus.d_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        stall    = 1'b0;
        emit     = 1'b0;
        addr_err = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (!mem_op) begin
                        emit = 1'b1;
                    end else if (misaligned) begin
                        emit     = 1'b1;
                        addr_err = 1'b1;
                    end else begin
                        req   = 1'b1;
                        stall = 1'b1;
                        if (dbus.d_addr_ok)
                            state_nx = WAIT;
                    end
                end else if (flush && mem_op && !misaligned && dbus.d_addr_ok) begin
                    // a response is still owed to the bus; drain it before accepting new work
                    state_nx = CANCEL;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dbus.d_data_ok)
                    state_nx = flush ? IDLE : DONE;
                else if (flush)
                    state_nx = CANCEL;
            end
            DONE: begin
                emit     = ~flush;
                state_nx = IDLE;
            end
            CANCEL: begin
                stall = 1'b1;
                if (dbus.d_data_ok)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_on  = req & ~rst;
    assign emit_on = emit & ~rst;

    assign stall_req    = stall & ~rst;
    assign dbus.d_req   = req_on;
    assign dbus.d_wr    = req_on & is_store;
    assign dbus.d_be    = req_on ? be : 4'b0000;
    assign dbus.d_addr  = req_on ? {in_daddr[AW-1:2], 2'b00} : '0;
    assign dbus.d_wdata = req_on ? wdata_lanes : '0;

    // every non-emitting cycle is a full bubble so memwb_reg never writes twice
    assign mem_memtype = emit_on ? in_memtype : 8'h00;
    assign mem_wreg    = emit_on & in_wreg & ~addr_err;
    assign mem_wa      = emit_on ? in_wa : 5'd0;
    assign mem_dreg    = !emit_on ? '0 : ((state == DONE && is_load) ? rdata_buf : in_alures);
    assign mem_dre     = (emit_on && is_load && !addr_err) ? be : 4'b0000;
    assign mem_daddr   = emit_on ? in_daddr : '0;
    assign mem_adel    = emit_on & addr_err & is_load;
    assign mem_ades    = emit_on & addr_err & is_store;
endmodule
